// File: rtl/irda_dma_sched.sv
// DMA channel scheduler for the IrDA core: arbitrates TX fill and RX drain
// requests round-robin and sequences bounded bursts with per-beat acks.
module irda_dma_sched #(
    parameter int FIFO_POINTER_W = 4,
    parameter int MAX_BURST      = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      use_dma,
    input  logic [FIFO_POINTER_W:0]   txfifo_count,
    input  logic [FIFO_POINTER_W:0]   rxfifo_count,
    input  logic [1:0]                tx_trigger_level,
    input  logic [1:0]                rx_trigger_level,
    input  logic                      rx_frame_end,
    output logic                      dma_req_o,
    output logic                      dma_dir_o,
    output logic [FIFO_POINTER_W:0]   burst_len_o,
    output logic                      dma_last_o,
    input  logic                      dma_ack_i,
    output logic                      dma_abort_o,
    output logic                      busy_o
);

    localparam int CW = FIFO_POINTER_W + 1;
    localparam int AW = FIFO_POINTER_W + 2;
    localparam logic [AW-1:0] DEPTH = AW'(2 ** FIFO_POINTER_W);
    localparam logic [AW-1:0] MAX_B = AW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t        state, state_n;
    logic          ptr_tx, ptr_n;      // 0: RX has priority, 1: TX has priority
    logic          flush, flush_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          dir, dir_n;
    logic [CW-1:0] len, len_n;
    logic          abort, abort_n;

    logic [AW-1:0] tx_free;
    logic [AW-1:0] rx_avail;
    logic [AW-1:0] avail;
    logic          tx_elig;
    logic          rx_elig;
    logic          grant;
    logic          grant_rx;

    function automatic logic [AW-1:0] level_of(input logic [1:0] t);
        logic [AW-1:0] l;
        case (t)
            2'b00:   l = AW'(1);
            2'b01:   l = DEPTH >> 2;
            2'b10:   l = DEPTH >> 1;
            default: l = DEPTH - AW'(2);
        endcase
        return l;
    endfunction

    assign tx_free  = DEPTH - {1'b0, txfifo_count};
    assign rx_avail = {1'b0, rxfifo_count};
    assign tx_elig  = use_dma & (tx_free >= level_of(tx_trigger_level));
    assign rx_elig  = use_dma & ((rx_avail >= level_of(rx_trigger_level)) |
                                 (flush & (rx_avail != '0)));
    assign grant_rx = rx_elig & (~tx_elig | ~ptr_tx);
    assign avail    = grant_rx ? rx_avail : tx_free;

    always_comb begin
        state_n = state;
        ptr_n   = ptr_tx;
        flush_n = flush;
        cnt_n   = cnt;
        dir_n   = dir;
        len_n   = len;
        abort_n = 1'b0;
        grant   = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_elig | rx_elig) begin
                    grant   = 1'b1;
                    state_n = S_REQ;
                    dir_n   = grant_rx;
                    len_n   = (avail > MAX_B) ? CW'(MAX_BURST) : avail[CW-1:0];
                    cnt_n   = (avail > MAX_B) ? CW'(MAX_BURST) : avail[CW-1:0];
                    ptr_n   = ~ptr_tx;
                end
            end
            S_REQ: begin
                // losing use_dma mid-burst takes precedence over a same-cycle ack
                if (!use_dma) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    abort_n = 1'b1;
                end else if (dma_ack_i) begin
                    if (cnt == CW'(1)) begin
                        state_n = S_GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
            end
            S_GAP: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if ((grant & grant_rx) | ((state == S_IDLE) & (rx_avail == '0)))
            flush_n = 1'b0;
        if (rx_frame_end)
            flush_n = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state  <= S_IDLE;
            ptr_tx <= 1'b0;
            flush  <= 1'b0;
            cnt    <= '0;
            dir    <= 1'b0;
            len    <= '0;
            abort  <= 1'b0;
        end else begin
            state  <= state_n;
            ptr_tx <= ptr_n;
            flush  <= flush_n;
            cnt    <= cnt_n;
            dir    <= dir_n;
            len    <= len_n;
            abort  <= abort_n;
        end
    end

    assign dma_req_o   = (state == S_REQ);
    assign busy_o      = (state != S_IDLE);
    assign dma_last_o  = (state == S_REQ) & (cnt == CW'(1));
    assign dma_dir_o   = dir;
    assign burst_len_o = len;
    assign dma_abort_o = abort;

endmodule

// File: tb/tb_irda_dma_sched.sv
// Scoreboard bench for irda_dma_sched: stimulus pushes expected bursts,
// a negedge monitor pops and compares them when dma_req_o rises.
module tb_irda_dma_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       use_dma = 1'b0;
    logic [4:0] txfifo_count = '0;
    logic [4:0] rxfifo_count = '0;
    logic [1:0] tx_trig = '0;
    logic [1:0] rx_trig = '0;
    logic       rx_frame_end = 1'b0;
    logic       dma_req_o;
    logic       dma_dir_o;
    logic [4:0] burst_len_o;
    logic       dma_last_o;
    logic       dma_ack_i = 1'b0;
    logic       dma_abort_o;
    logic       busy_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       dir;
        logic [4:0] len;
    } burst_t;

    burst_t exp_q[$];
    burst_t got;
    logic   req_q = 1'b0;

    irda_dma_sched #(.FIFO_POINTER_W(4), .MAX_BURST(8)) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst_n),
        .use_dma          (use_dma),
        .txfifo_count     (txfifo_count),
        .rxfifo_count     (rxfifo_count),
        .tx_trigger_level (tx_trig),
        .rx_trigger_level (rx_trig),
        .rx_frame_end     (rx_frame_end),
        .dma_req_o        (dma_req_o),
        .dma_dir_o        (dma_dir_o),
        .burst_len_o      (burst_len_o),
        .dma_last_o       (dma_last_o),
        .dma_ack_i        (dma_ack_i),
        .dma_abort_o      (dma_abort_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d, input logic [4:0] l);
        burst_t b;
        b.dir = d;
        b.len = l;
        exp_q.push_back(b);
    endtask

    // Scoreboard monitor: one expected entry per burst start
    always @(negedge clk) begin
        if (dma_req_o && !req_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_burst", 32'd1, 32'd0);
            end else begin
                got = exp_q.pop_front();
                check("burst_dir", dma_dir_o, got.dir);
                check("burst_len", burst_len_o, got.len);
            end
        end
        req_q = dma_req_o;
    end

    task automatic wait_req(input string name);
        int k = 0;
        while (!dma_req_o && k < 20) begin
            step();
            k++;
        end
        check(name, dma_req_o, 1);
    endtask

    task automatic run_burst(input int n, input logic [4:0] len, input bit gap, input bit stop);
        wait_req("req_seen");
        if (!dma_req_o) return;
        for (int i = 0; i < n; i++) begin
            dma_ack_i = 1'b1;
            check("last_beat", dma_last_o, (i == n - 1));
            if (i == n - 1) check("len_stable", burst_len_o, len);
            step();
            if (gap && i != n - 1) begin
                dma_ack_i = 1'b0;
                check("gap_len", burst_len_o, len);
                check("gap_req_held", dma_req_o, 1);
                step();
            end
        end
        dma_ack_i = 1'b0;
        if (stop) use_dma = 1'b0;
        check("gap_req", dma_req_o, 0);
        check("gap_busy", busy_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_req", dma_req_o, 0);
        check("rst_dir", dma_dir_o, 0);
        check("rst_len", burst_len_o, 0);
        check("rst_last", dma_last_o, 0);
        check("rst_abort", dma_abort_o, 0);
        check("rst_busy", busy_o, 0);
        step();
        rst_n = 1'b1;

        // RX burst of 4 at trigger D/4
        use_dma = 1'b1; rx_trig = 2'b01; rxfifo_count = 5'd4;
        txfifo_count = 5'd16; tx_trig = 2'b00;
        push(1'b1, 5'd4);
        step();
        check("s1_req_one_cycle", dma_req_o, 1);
        run_burst(4, 5'd4, 1'b0, 1'b1);
        step();
        check("s1_busy_low", busy_o, 0);
        check("s1_req_low", dma_req_o, 0);

        // TX only, capped at MAX_BURST, acks with gaps
        rxfifo_count = 5'd0; txfifo_count = 5'd2; tx_trig = 2'b10; use_dma = 1'b1;
        push(1'b0, 5'd8);
        run_burst(8, 5'd8, 1'b1, 1'b1);
        step();

        // Both eligible: alternate RX, TX, RX, TX
        txfifo_count = 5'd14; tx_trig = 2'b00; rxfifo_count = 5'd4; rx_trig = 2'b01;
        use_dma = 1'b1;
        push(1'b1, 5'd4); push(1'b0, 5'd2); push(1'b1, 5'd4); push(1'b0, 5'd2);
        run_burst(4, 5'd4, 1'b0, 1'b0);
        check("s3_spacing_idle", dma_req_o, 0);
        step();
        check("s3_spacing_idle2", dma_req_o, 0);
        run_burst(2, 5'd2, 1'b0, 1'b0);
        run_burst(4, 5'd4, 1'b0, 1'b0);
        run_burst(2, 5'd2, 1'b0, 1'b1);
        step();

        // Frame-end flush below trigger
        rxfifo_count = 5'd3; rx_trig = 2'b11; txfifo_count = 5'd16; tx_trig = 2'b00;
        use_dma = 1'b1;
        step(); step();
        check("s4_no_req_below_trig", dma_req_o, 0);
        rx_frame_end = 1'b1;
        step();
        rx_frame_end = 1'b0;
        push(1'b1, 5'd3);
        run_burst(3, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("s4_flush_cleared", dma_req_o, 0);
        rxfifo_count = 5'd0;
        for (int i = 0; i < 3; i++) step();
        check("s4_no_req_empty", dma_req_o, 0);
        use_dma = 1'b0;
        step();

        // Abort after 2 of 6 beats
        rxfifo_count = 5'd6; rx_trig = 2'b01; txfifo_count = 5'd16; use_dma = 1'b1;
        push(1'b1, 5'd6);
        wait_req("s5_req");
        dma_ack_i = 1'b1;
        step(); step();
        check("s5_last_mid", dma_last_o, 0);
        use_dma = 1'b0;
        step();
        check("s5_req_dropped", dma_req_o, 0);
        check("s5_abort_pulse", dma_abort_o, 1);
        check("s5_idle", busy_o, 0);
        step();
        check("s5_abort_once", dma_abort_o, 0);
        step(); step();
        check("s5_stray_req", dma_req_o, 0);
        check("s5_stray_busy", busy_o, 0);
        check("s5_stray_last", dma_last_o, 0);
        dma_ack_i = 1'b0;

        // Async reset mid-burst, then priority back at RX
        rxfifo_count = 5'd0; txfifo_count = 5'd14; tx_trig = 2'b00; use_dma = 1'b1;
        push(1'b0, 5'd2);
        wait_req("s6_req");
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_req", dma_req_o, 0);
        check("s6_async_busy", busy_o, 0);
        rxfifo_count = 5'd4; rx_trig = 2'b01;
        step(); step();
        rst_n = 1'b1;
        push(1'b1, 5'd4);
        run_burst(4, 5'd4, 1'b0, 1'b1);
        step(); step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
